// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
// Latency: none, wires only.
// Backpressure: none; the control unit stalls on busy until the done pulse.
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              mult_start;
  logic              div_start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              busy;
  logic              done;
  logic              div_zero;

  // Control unit side: issues requests, consumes results.
  modport master (
    output mult_start, div_start, a, b,
    input  hi_out, lo_out, busy, done, div_zero
  );

  // Unit side: consumes requests, produces results.
  modport slave (
    input  mult_start, div_start, a, b,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (shift-add) / DIV (restoring) unit producing HI/LO.
// Latency: done pulses 33 clocks after the start edge; divide-by-zero answers next cycle.
// Backpressure: starts seen while busy are dropped; a start in the done cycle is accepted.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_CALC = 2'd1,
    DIV_CALC = 2'd2,
    FIX      = 2'd3
  } state_t;

  // The last iteration index; the counter leaves CALC after DATA_W steps.
  localparam logic [5:0] LAST_CNT = 6'(DATA_W - 1);

  state_t              r_state;
  logic [5:0]          r_cnt;
  logic                r_is_div;
  logic                r_sign_a;
  logic                r_sign_b;
  // Multiplier (shifted right) for MULT; dividend shifting out / quotient shifting in for DIV.
  logic [DATA_W-1:0]   r_mag_a;
  // Divisor magnitude for DIV.
  logic [DATA_W-1:0]   r_mag_b;
  // Multiplicand magnitude, shifted left one place per step.
  logic [2*DATA_W-1:0] r_mcand;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_rem;

  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_busy;
  logic                r_done;
  logic                r_div_zero;

  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_trial;
  logic                w_q_bit;
  logic [2*DATA_W-1:0] w_prod_s;
  logic [DATA_W-1:0]   w_quo_s;
  logic [DATA_W-1:0]   w_rem_s;

  // Operand magnitudes, restoring-divide step and final sign correction.
  always_comb begin
    // Negating 0x80000000 wraps to itself, which is the right unsigned magnitude.
    w_abs_a  = bus.a[DATA_W-1] ? (~bus.a + 1'b1) : bus.a;
    w_abs_b  = bus.b[DATA_W-1] ? (~bus.b + 1'b1) : bus.b;
    // Remainder < |b| <= 2^31, so one extra bit holds the shifted value and the borrow.
    w_rem_sh = {r_rem, r_mag_a[DATA_W-1]};
    w_trial  = w_rem_sh - {1'b0, r_mag_b};
    w_q_bit  = ~w_trial[DATA_W];
    w_prod_s = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
    w_quo_s  = (r_sign_a ^ r_sign_b) ? (~r_mag_a + 1'b1) : r_mag_a;
    w_rem_s  = r_sign_a ? (~r_rem + 1'b1) : r_rem;
  end

  // Control FSM and datapath with every output registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mult_start) begin
            r_sign_a <= bus.a[DATA_W-1];
            r_sign_b <= bus.b[DATA_W-1];
            r_mag_a  <= w_abs_a;
            r_mag_b  <= w_abs_b;
            r_mcand  <= {{DATA_W{1'b0}}, w_abs_b};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= MUL_CALC;
          end else if (bus.div_start) begin
            if (bus.b == '0) begin
              // Nothing to compute; flag it and leave HI/LO as they were.
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_sign_a <= bus.a[DATA_W-1];
              r_sign_b <= bus.b[DATA_W-1];
              r_mag_a  <= w_abs_a;
              r_mag_b  <= w_abs_b;
              r_rem    <= '0;
              r_cnt    <= '0;
              r_is_div <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= DIV_CALC;
            end
          end
        end

        MUL_CALC: begin
          if (r_mag_a[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_mag_a <= r_mag_a >> 1;
          r_cnt   <= r_cnt + 6'd1;
          if (r_cnt == LAST_CNT) begin
            r_state <= FIX;
          end
        end

        DIV_CALC: begin
          r_rem   <= w_q_bit ? w_trial[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
          r_mag_a <= {r_mag_a[DATA_W-2:0], w_q_bit};
          r_cnt   <= r_cnt + 6'd1;
          if (r_cnt == LAST_CNT) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_s;
            r_lo <= w_quo_s;
          end else begin
            r_hi <= w_prod_s[2*DATA_W-1:DATA_W];
            r_lo <= w_prod_s[DATA_W-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: reference results queued at issue, checked on done.
// Latency: checks done arrives 33 clocks after the start edge (next cycle for div-by-zero).
// Backpressure: exercises ignored starts while busy and an asynchronous abort.
module tb_mult_div_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk;
  logic reset;
  mult_div_unit_if #(.DATA_W(32)) bus ();

  mult_div_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  int          n_chk;
  int          n_pass;
  logic [31:0] last_hi;
  logic [31:0] last_lo;
  int          done_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: 64-bit signed arithmetic, truncating divide.
  function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      r = sa * sb;
      u = r;
      e = '{hi: u[63:32], lo: u[31:0], dz: 1'b0};
    end else if (b == 32'd0) begin
      e = '{hi: last_hi, lo: last_lo, dz: 1'b1};
    end else begin
      r = sa / sb;
      u = r;
      e.lo = u[31:0];
      r = sa % sb;
      u = r;
      e.hi = u[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Pop and compare every result the unit announces.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi_out", {32'd0, bus.hi_out}, {32'd0, e.hi});
        check("lo_out", {32'd0, bus.lo_out}, {32'd0, e.lo});
        check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
      end
    end
  end

  // Issue one operation, queue its expected result and check timing of busy/done.
  task automatic run_op(input bit is_div, input bit both, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    exp_t e;
    int   lat;
    int   busy_cnt;
    @(negedge clk);
    bus.a          = a;
    bus.b          = b;
    bus.mult_start = !is_div || both;
    bus.div_start  = is_div || both;
    e = model(is_div && !both, a, b);
    sb_q.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    // Operands must be ignored once the start edge has passed.
    bus.a = $urandom;
    bus.b = $urandom;
    if (is_div && !both && b == 32'd0) begin
      check({tag, "_dz_done"}, {63'd0, bus.done}, 64'd1);
      check({tag, "_dz_busy"}, {63'd0, bus.busy}, 64'd0);
      return;
    end
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    n_chk          = 0;
    n_pass         = 0;
    done_seen      = 0;
    last_hi        = 32'd0;
    last_lo        = 32'd0;
    reset          = 1'b1;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.a          = 32'd0;
    bus.b          = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_hi", {32'd0, bus.hi_out}, 64'd0);
    check("rst_lo", {32'd0, bus.lo_out}, 64'd0);
    check("rst_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    reset = 1'b0;

    // Signed multiply, including the most-negative corner and start priority.
    run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, "m7xm3");
    check("m7xm3_lo_const", {32'd0, bus.lo_out}, 64'hFFFF_FFEB);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, "mminxmin");
    run_op(1'b0, 1'b1, 32'd6, 32'd4, "both_starts");

    // Truncating divide; remainder follows the dividend's sign.
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, "dm7d2");
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, "d7dm2");
    check("d7dm2_hi_const", {32'd0, bus.hi_out}, 64'd1);

    // Divide by zero keeps the previous HI/LO.
    run_op(1'b1, 1'b0, 32'h0000_0451, 32'h0000_0020, "d_setup");
    run_op(1'b1, 1'b0, 32'd5, 32'd0, "div0");
    check("div0_hi_kept", {32'd0, bus.hi_out}, 64'h11);

    // Overflow wraps without a flag.
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "dovf");

    // A second start while busy is dropped.
    @(negedge clk);
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.mult_start = 1'b1;
    sb_q.push_back('{hi: 32'd0, lo: 32'd15, dz: 1'b0});
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a = 32'd9;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("ignored_start_done", {63'd0, bus.done}, 64'd1);
    @(negedge clk);
    check("ignored_start_idle", {63'd0, bus.busy}, 64'd0);

    // Asynchronous abort mid-operation: outputs clear at once, no result follows.
    @(negedge clk);
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_hi", {32'd0, bus.hi_out}, 64'd0);
    check("abort_lo", {32'd0, bus.lo_out}, 64'd0);
    check("abort_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    cnt = done_seen;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_seen - cnt), 64'd0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, "post_abort");

    // A few random operations.
    for (int i = 0; i < 6; i++) begin
      run_op(i[0], 1'b0, $urandom, $urandom, "rand");
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide unit for MULT and DIV, sitting downstream of the control unit and beside the ALU in the datapath. The control unit pulses a start signal and stalls in a wait state until done. It then writes hi_out/lo_out into the datapath HI/LO registers using its own hi_w/lo_w. Divide-by-zero is reported for the control unit's exception path, with epc_w and the exception handling owned by the control unit.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W; only 32 is supported.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mult_start  in  1  one-cycle request for a signed multiply of a*b
div_start  in  1  one-cycle request for a signed divide a/b
a  in  DATA_W  operand A (rs)
b  in  DATA_W  operand B (rt)
hi_out  out  DATA_W  MULT: product[63:32]; DIV: remainder
lo_out  out  DATA_W  MULT: product[31:0]; DIV: quotient
busy  out  1  operation in progress
done  out  1  one-cycle pulse: result (or div_zero) valid
div_zero  out  1  one-cycle pulse alongside done when DIV had b==0

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
  - State=IDLE, iteration counter=0, internal magnitude/sign registers cleared.
  - No result is produced for an aborted operation.
- States: IDLE, MUL_CALC, DIV_CALC, FIX. All outputs are registered.
- IDLE, at edge E0 with a start sampled high:
  - Latch |a|, |b|, sign_a, sign_b; counter=0.
  - mult_start has priority if both starts are high.
  - Go to MUL_CALC or DIV_CALC; busy=1 from E0.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit.
- div_start with b==0:
  - No calculation is run.
  - At E0 the unit stays in IDLE and pulses done=1 and div_zero=1 for one cycle.
  - busy stays 0; hi_out/lo_out are unchanged.
- MUL_CALC: unsigned shift-add, one multiplier bit per cycle, LSB first, into a 64-bit accumulator.
  - Runs at edges E1..E32; counter increments and leaves at count 32 to FIX.
- DIV_CALC: restoring division, one quotient bit per cycle, MSB first.
  - Each cycle: shift the remainder left, bring in the next dividend bit, trial-subtract |b|.
  - On non-negative trial: keep the difference and set the quotient bit to 1; otherwise restore and set 0.
  - Runs at edges E1..E32, then goes to FIX.
- FIX, at E33:
  - MULT: if sign_a^sign_b, negate the 64-bit product (two's complement); hi_out=prod[63:32], lo_out=prod[31:0].
  - DIV: quotient negated if sign_a^sign_b; remainder negated if sign_a (truncating division; remainder takes the dividend's sign).
  - busy=0, done=1 for exactly one cycle, state=IDLE.
- Latency: done high in the cycle after E33, i.e. 33 clocks after the start edge.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000, hi_out=0 with no flag.
- Start pulses while busy=1 are ignored, with no queuing. A start sampled in the same cycle done is high is accepted.
- hi_out/lo_out hold their value until the next FIX or reset. Operands a/b may change after E0 without effect.

Test Plan:
1. mult_start, a=7, b=0xFFFFFFFD (-3) -> busy=1 for 33 cycles; done pulse at start+33; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
2. mult_start, a=b=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000; mult_start and div_start both high with a=6, b=4 -> MULT runs: hi_out=0, lo_out=24.
3. div_start, a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); then a=7, b=0xFFFFFFFE -> lo_out=0xFFFFFFFD, hi_out=1.
4. After a result of hi_out=0x11, lo_out=0x22, div_start with a=5, b=0 -> at the next cycle done=1, div_zero=1, busy=0, hi_out=0x11, lo_out=0x22 unchanged.
5. div_start, a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0.
6. mult_start a=3, b=5; pulse mult_start again at cycle 5 with a=9 (ignored) -> lo_out=15. Second run: assert reset at cycle 10 -> all outputs 0 immediately (asynchronous), no done pulse follows; after release a fresh mult_start completes normally.
